// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Sample positions are tick indices within one 16-tick bit period.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned SAMPLE_MID_LO = 7;
  localparam int unsigned SAMPLE_MID    = 8;
  localparam int unsigned SAMPLE_MID_HI = 9;
  localparam int unsigned TICK_LAST     = 15;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq_hz,
                                           input int unsigned baud_rate);
    return clk_freq_hz / (baud_rate * 16);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: rdata_o always presents the head entry.
// A pop on a full FIFO frees the slot for a same-cycle push.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x tick generator, majority-vote
// bit sampling FSM, receive FIFO and sticky framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  input  logic       rd_i,
  input  logic       clr_err_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_err_o
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  logic              rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t         state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              s_lo_q, s_lo_d;
  logic              s_mid_q, s_mid_d;
  logic              brk_q, brk_d;
  logic              push_q, push_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_err_q, overrun_err_d;
  logic              tick, maj, at_mid_hi, at_last, frame_set, overrun_set;
  logic              fifo_empty, fifo_full;

  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  assign at_mid_hi = tick && (tick_cnt_q == TICK_W'(SAMPLE_MID_HI));
  assign at_last   = tick && (tick_cnt_q == TICK_W'(TICK_LAST));
  // Third vote is the live sample taken at tick SAMPLE_MID_HI.
  assign maj = (s_lo_q & s_mid_q) | (s_lo_q & rx_s_q) | (s_mid_q & rx_s_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    tick_cnt_d = tick ? tick_cnt_q + TICK_W'(1) : tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    s_lo_d     = s_lo_q;
    s_mid_d    = s_mid_q;
    brk_d      = brk_q & ~rx_s_q;
    push_d     = 1'b0;
    frame_set  = 1'b0;

    if (tick && (tick_cnt_q == TICK_W'(SAMPLE_MID_LO))) begin
      s_lo_d = rx_s_q;
    end
    if (tick && (tick_cnt_q == TICK_W'(SAMPLE_MID))) begin
      s_mid_d = rx_s_q;
    end

    unique case (state_q)
      IDLE: begin
        if (!brk_q && rx_prev_q && !rx_s_q) begin
          state_d    = START;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (at_mid_hi && maj) begin
          state_d = IDLE;
        end else if (at_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (at_mid_hi) begin
          shift_d = {maj, shift_q[7:1]};
        end
        if (at_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leave early so a back-to-back start edge is not missed.
        if (at_mid_hi) begin
          state_d = IDLE;
          if (maj) begin
            push_d = 1'b1;
          end else begin
            frame_set = 1'b1;
            brk_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the push cycle makes room, so no overrun then.
  assign overrun_set = push_q & fifo_full & ~rd_i;

  always_comb begin
    frame_err_d = frame_err_q;
    if (frame_set) begin
      frame_err_d = 1'b1;
    end else if (clr_err_i) begin
      frame_err_d = 1'b0;
    end
    overrun_err_d = overrun_err_q;
    if (overrun_set) begin
      overrun_err_d = 1'b1;
    end else if (clr_err_i) begin
      overrun_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      s_lo_q        <= 1'b1;
      s_mid_q       <= 1'b1;
      brk_q         <= 1'b0;
      push_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_i;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      s_lo_q        <= s_lo_d;
      s_mid_q       <= s_mid_d;
      brk_q         <= brk_d;
      push_q        <= push_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (rd_i),
    .rdata_o (data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign valid_o       = ~fifo_empty;
  assign full_o        = fifo_full;
  assign busy_o        = (state_q != IDLE);
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;

endmodule
